// File: rtl/rgb_hue_pwm.sv
// rgb_hue_pwm: six-segment hue wheel driver for the board RGB LED.
// Per-channel PWM fade or hard colour steps, frame-latched duties.
module rgb_hue_pwm #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 7813,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       step_mode,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B,
   output logic [2:0] segment,
   output logic       cycle_done
);

   localparam int PW =
      (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST =
      PW'(STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] MAX = '1;
   localparam logic PIN_OFF = ACTIVE_LOW;

   logic [PW-1:0]       r_pre;
   logic [PWM_BITS-1:0] r_lvl;
   logic [2:0]          r_seg;
   logic                r_wrap;
   logic                r_done;
   logic [PWM_BITS-1:0] r_cnt;
   logic [PWM_BITS-1:0] r_duty_r;
   logic [PWM_BITS-1:0] r_duty_g;
   logic [PWM_BITS-1:0] r_duty_b;
   logic                r_pin_r;
   logic                r_pin_g;
   logic                r_pin_b;

   logic                w_tick;
   logic                w_lvl_last;
   logic                w_wrap;
   logic                w_frame_end;
   logic [PWM_BITS-1:0] w_up;
   logic [PWM_BITS-1:0] w_dn;
   logic [PWM_BITS-1:0] w_tgt_r;
   logic [PWM_BITS-1:0] w_tgt_g;
   logic [PWM_BITS-1:0] w_tgt_b;
   logic                w_on_r;
   logic                w_on_g;
   logic                w_on_b;

   assign w_tick      = enable && (r_pre == PRE_LAST);
   assign w_lvl_last  = (r_lvl == MAX);
   assign w_wrap      = w_tick && w_lvl_last
                        && (r_seg == 3'd5);
   assign w_frame_end = (r_cnt == MAX);
   assign w_up        = r_lvl;
   assign w_dn        = MAX - r_lvl;

   // Prescaler: divides the clock down to brightness steps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (enable) begin
         if (w_tick) r_pre <= '0;
         else        r_pre <= r_pre + 1'b1;
      end
   end

   // Level and segment: walk the hue wheel one step per tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lvl <= '0;
         r_seg <= 3'd0;
      end else if (w_tick) begin
         r_lvl <= r_lvl + 1'b1;
         if (w_lvl_last) begin
            if (r_seg == 3'd5) r_seg <= 3'd0;
            else               r_seg <= r_seg + 3'd1;
         end
      end
   end

   // Wrap flag is staged once so the pulse lands a cycle
   // after the segment has already shown 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrap <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_wrap <= w_wrap;
         r_done <= r_wrap;
      end
   end

   // Target duties from segment, level and mode.
   always_comb begin
      w_tgt_r = '0;
      w_tgt_g = '0;
      w_tgt_b = '0;
      if (step_mode) begin
         case (r_seg)
            3'd0: begin w_tgt_r = MAX; end
            3'd1: begin
               w_tgt_r = MAX;
               w_tgt_g = MAX;
            end
            3'd2: begin w_tgt_g = MAX; end
            3'd3: begin
               w_tgt_g = MAX;
               w_tgt_b = MAX;
            end
            3'd4: begin w_tgt_b = MAX; end
            3'd5: begin
               w_tgt_r = MAX;
               w_tgt_b = MAX;
            end
            default: begin end
         endcase
      end else begin
         case (r_seg)
            3'd0: begin
               w_tgt_r = MAX;
               w_tgt_g = w_up;
            end
            3'd1: begin
               w_tgt_r = w_dn;
               w_tgt_g = MAX;
            end
            3'd2: begin
               w_tgt_g = MAX;
               w_tgt_b = w_up;
            end
            3'd3: begin
               w_tgt_g = w_dn;
               w_tgt_b = MAX;
            end
            3'd4: begin
               w_tgt_r = w_up;
               w_tgt_b = MAX;
            end
            3'd5: begin
               w_tgt_r = MAX;
               w_tgt_b = w_dn;
            end
            default: begin end
         endcase
      end
   end

   // Free-running PWM counter, independent of enable.
   always_ff @(posedge clk) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
   end

   // Duties only change on the frame boundary.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_duty_r <= '0;
         r_duty_g <= '0;
         r_duty_b <= '0;
      end else if (w_frame_end) begin
         r_duty_r <= w_tgt_r;
         r_duty_g <= w_tgt_g;
         r_duty_b <= w_tgt_b;
      end
   end

   assign w_on_r = enable && (r_cnt < r_duty_r);
   assign w_on_g = enable && (r_cnt < r_duty_g);
   assign w_on_b = enable && (r_cnt < r_duty_b);

   // Registered pins with selectable polarity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pin_r <= PIN_OFF;
         r_pin_g <= PIN_OFF;
         r_pin_b <= PIN_OFF;
      end else begin
         r_pin_r <= w_on_r ^ PIN_OFF;
         r_pin_g <= w_on_g ^ PIN_OFF;
         r_pin_b <= w_on_b ^ PIN_OFF;
      end
   end

   assign RGB_R      = r_pin_r;
   assign RGB_G      = r_pin_g;
   assign RGB_B      = r_pin_b;
   assign segment    = r_seg;
   assign cycle_done = r_done;

endmodule

// File: tb/tb_rgb_hue_pwm.sv
// tb_rgb_hue_pwm: table vectors, corner sequences and random
// stimulus against a hue-wheel reference model, both polarities.
module tb_rgb_hue_pwm;

   localparam int PB   = 3;
   localparam int STEP = 4;
   localparam int NLV  = 1 << PB;
   localparam int MAXV = NLV - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       step_mode;
   logic       r0, g0, b0, d0;
   logic       r1, g1, b1, d1;
   logic [2:0] s0, s1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rgb_hue_pwm #(
      .PWM_BITS(PB), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b1)
   ) dut_lo (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .step_mode(step_mode), .RGB_R(r0), .RGB_G(g0),
      .RGB_B(b0), .segment(s0), .cycle_done(d0)
   );

   rgb_hue_pwm #(
      .PWM_BITS(PB), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b0)
   ) dut_hi (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .step_mode(step_mode), .RGB_R(r1), .RGB_G(g1),
      .RGB_B(b1), .segment(s1), .cycle_done(d1)
   );

   // Channel behaviour per segment: 0 off, 1 full, 2 rising, 3 falling
   int fk [6][3] = '{'{1,2,0}, '{3,1,0}, '{0,1,2},
                     '{0,3,1}, '{2,0,1}, '{1,0,3}};
   int sk [6][3] = '{'{1,0,0}, '{1,1,0}, '{0,1,0},
                     '{0,1,1}, '{0,0,1}, '{1,0,1}};

   // Model state: enabled clocks since reset, clocks since reset
   int m_a, m_n, m_prev;
   int m_duty [3];
   int e_on [3];
   int e_seg, e_done;

   function automatic int kval(int k, int lvl);
      case (k)
         0: return 0;
         1: return MAXV;
         2: return lvl;
         default: return MAXV - lvl;
      endcase
   endfunction

   task automatic chk(input string nm, input int act,
                      input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic tick(input logic en, input logic sm,
                       input logic rn);
      int steps, lvl, seg, cnt;
      enable = en;
      step_mode = sm;
      rst_n = rn;
      @(posedge clk);
      if (!rn) begin
         m_a = 0;
         m_n = 0;
         m_prev = 0;
         for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            e_on[c] = 0;
         end
         e_seg = 0;
         e_done = 0;
      end else begin
         steps = m_a / STEP;
         lvl = steps % NLV;
         seg = (steps / NLV) % 6;
         cnt = m_n % NLV;
         for (int c = 0; c < 3; c++)
            e_on[c] = (en && cnt < m_duty[c]) ? 1 : 0;
         if (cnt == MAXV)
            for (int c = 0; c < 3; c++)
               m_duty[c] = kval(sm ? sk[seg][c] : fk[seg][c],
                                lvl);
         e_done = (seg == 0 && m_prev == 5) ? 1 : 0;
         m_prev = seg;
         if (en) m_a++;
         m_n++;
         e_seg = ((m_a / STEP) / NLV) % 6;
      end
      #1;
      chk("R_lo", int'(r0), 1 - e_on[0]);
      chk("G_lo", int'(g0), 1 - e_on[1]);
      chk("B_lo", int'(b0), 1 - e_on[2]);
      chk("R_hi", int'(r1), e_on[0]);
      chk("G_hi", int'(g1), e_on[1]);
      chk("B_hi", int'(b1), e_on[2]);
      chk("seg_lo", int'(s0), e_seg);
      chk("seg_hi", int'(s1), e_seg);
      chk("done_lo", int'(d0), e_done);
      chk("done_hi", int'(d1), e_done);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_to(input int k, input logic en,
                         input logic sm);
      while (m_n < k) tick(en, sm, 1'b1);
   endtask

   typedef struct {
      int clk_no;
      int seg;
      int done;
   } seq_t;

   typedef struct {
      logic sm;
      int   first;
      int   r, g, b;
   } frm_t;

   seq_t sv [9];
   frm_t fv [10];

   initial begin
      int cr0, cg0, cb0, cr1, cg1, cb1, held, cnt_r;
      logic sm;
      enable = 1'b0;
      step_mode = 1'b0;
      rst_n = 1'b0;

      sv[0] = '{31, 0, 0};  sv[1] = '{32, 1, 0};
      sv[2] = '{191, 5, 0}; sv[3] = '{192, 0, 0};
      sv[4] = '{193, 0, 1}; sv[5] = '{194, 0, 0};
      sv[6] = '{384, 0, 0}; sv[7] = '{385, 0, 1};
      sv[8] = '{386, 0, 0};

      fv[0] = '{1'b0, 9, 7, 1, 0};
      fv[1] = '{1'b0, 17, 7, 3, 0};
      fv[2] = '{1'b0, 25, 7, 5, 0};
      fv[3] = '{1'b0, 41, 6, 7, 0};
      fv[4] = '{1'b1, 17, 7, 0, 0};
      fv[5] = '{1'b1, 49, 7, 7, 0};
      fv[6] = '{1'b1, 81, 0, 7, 0};
      fv[7] = '{1'b1, 113, 0, 7, 7};
      fv[8] = '{1'b1, 145, 0, 0, 7};
      fv[9] = '{1'b1, 177, 7, 0, 7};

      // reset state and segment/cycle_done timeline
      do_reset();
      chk("rst_R", int'(r0), 1);
      chk("rst_R_hi", int'(r1), 0);
      for (int i = 0; i < 9; i++) begin
         run_to(sv[i].clk_no, 1'b1, 1'b0);
         chk($sformatf("tl_seg@%0d", sv[i].clk_no),
             int'(s0), sv[i].seg);
         chk($sformatf("tl_done@%0d", sv[i].clk_no),
             int'(d0), sv[i].done);
      end

      // on-time per frame, fade and step colours
      for (int i = 0; i < 10; i++) begin
         do_reset();
         run_to(fv[i].first - 1, 1'b1, fv[i].sm);
         cr0 = 0; cg0 = 0; cb0 = 0;
         cr1 = 0; cg1 = 0; cb1 = 0;
         for (int j = 0; j < NLV; j++) begin
            tick(1'b1, fv[i].sm, 1'b1);
            cr0 += int'(!r0); cg0 += int'(!g0);
            cb0 += int'(!b0);
            cr1 += int'(r1); cg1 += int'(g1);
            cb1 += int'(b1);
         end
         chk($sformatf("frm%0d_R", i), cr0, fv[i].r);
         chk($sformatf("frm%0d_G", i), cg0, fv[i].g);
         chk($sformatf("frm%0d_B", i), cb0, fv[i].b);
         chk($sformatf("frm%0d_Rh", i), cr1, fv[i].r);
         chk($sformatf("frm%0d_Gh", i), cg1, fv[i].g);
         chk($sformatf("frm%0d_Bh", i), cb1, fv[i].b);
      end

      // enable dropped mid-segment-2 for 100 clocks
      do_reset();
      run_to(80, 1'b1, 1'b0);
      held = int'(s0);
      tick(1'b0, 1'b0, 1'b1);
      chk("dis_pins", int'({r0, g0, b0}), 7);
      chk("dis_pins_hi", int'({r1, g1, b1}), 0);
      for (int i = 0; i < 99; i++) tick(1'b0, 1'b0, 1'b1);
      chk("dis_seg_held", int'(s0), held);
      run_to(195, 1'b1, 1'b0);
      chk("resume_seg2", int'(s0), 2);
      tick(1'b1, 1'b0, 1'b1);
      chk("resume_seg3", int'(s0), 3);

      // step_mode toggled mid-frame takes effect next frame
      do_reset();
      run_to(43, 1'b1, 1'b0);
      cnt_r = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         cnt_r += int'(!r0);
      end
      chk("toggle_old_R", cnt_r, 3);
      cnt_r = 0;
      for (int i = 0; i < NLV; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         cnt_r += int'(!r0);
      end
      chk("toggle_new_R", cnt_r, 7);

      // one-clock reset pulse in segment 4
      do_reset();
      run_to(140, 1'b1, 1'b0);
      chk("pre_rst_seg4", int'(s0), 4);
      tick(1'b1, 1'b0, 1'b0);
      chk("rp_seg", int'(s0), 0);
      chk("rp_pins", int'({r0, g0, b0}), 7);
      chk("rp_pins_hi", int'({r1, g1, b1}), 0);
      chk("rp_done", int'(d0), 0);

      // randomized enable / mode / reset against the model
      do_reset();
      sm = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) sm = ~sm;
         tick(($urandom_range(0, 9) != 0),
              sm, ($urandom_range(0, 799) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
